// File: rtl/alm_pkg.sv
// Shared definitions for the approximate-log-multiplier reduction datapath:
// FSM states, product width and signed saturation limits.
package alm_pkg;

    localparam int PROD_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Largest signed value representable in w bits (w <= 32), as a 32-bit pattern.
    function automatic logic signed [31:0] sat_max(input int w);
        return (32'sd1 <<< (w - 1)) - 32'sd1;
    endfunction

    // Most negative signed value in w bits; its low w bits are the complement of sat_max.
    function automatic logic signed [31:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/alm_sat_add.sv
// Combinational signed add of an accumulator and a 16-bit product,
// clamped to the accumulator range with an overflow flag.
module alm_sat_add
    import alm_pkg::*;
#(
    parameter int ACC_WIDTH = 24
) (
    input  logic [ACC_WIDTH-1:0]  acc,
    input  logic [PROD_WIDTH-1:0] prod,
    output logic [ACC_WIDTH-1:0]  sum,
    output logic                  ovf
);

    logic signed [ACC_WIDTH:0] wide;
    logic [ACC_WIDTH-1:0]      max_v;
    logic [ACC_WIDTH-1:0]      min_v;

    assign max_v = ACC_WIDTH'(sat_max(ACC_WIDTH));
    assign min_v = ACC_WIDTH'(sat_min(ACC_WIDTH));

    // One guard bit is enough: the product is never wider than the accumulator.
    assign wide = $signed({acc[ACC_WIDTH-1], acc})
                + $signed({{(ACC_WIDTH + 1 - PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod});

    always_comb begin
        ovf = wide[ACC_WIDTH] != wide[ACC_WIDTH-1];
        sum = wide[ACC_WIDTH-1:0];
        if (ovf) begin
            sum = wide[ACC_WIDTH] ? min_v : max_v;
        end
    end

endmodule

// File: rtl/alm_dot_accum.sv
// Streaming saturating dot-product accumulator: sums VEC_LEN signed products
// and hands each result out on a valid/ready port.
module alm_dot_accum
    import alm_pkg::*;
#(
    parameter int VEC_LEN   = 8,
    parameter int ACC_WIDTH = 24
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [PROD_WIDTH-1:0] i_prod,
    input  logic                  i_clear,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [ACC_WIDTH-1:0]  o_acc,
    output logic                  o_sat,
    output logic [7:0]            o_count
);

    state_t               state_reg;
    logic [ACC_WIDTH-1:0] acc_reg;
    logic [7:0]           count_reg;
    logic                 sticky_reg;

    logic [ACC_WIDTH-1:0] sum;
    logic                 ovf;
    logic                 accept;
    logic                 last_term;

    alm_sat_add #(
        .ACC_WIDTH(ACC_WIDTH)
    ) u_sat_add (
        .acc  (acc_reg),
        .prod (i_prod),
        .sum  (sum),
        .ovf  (ovf)
    );

    // o_ready is a register, so it is already low whenever the FSM sits in HOLD.
    assign accept    = i_valid && o_ready;
    assign last_term = count_reg == 8'(VEC_LEN - 1);
    assign o_count   = count_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            count_reg  <= '0;
            sticky_reg <= 1'b0;
            o_ready    <= 1'b0;
            o_valid    <= 1'b0;
            o_acc      <= '0;
            o_sat      <= 1'b0;
        end else if (i_clear) begin
            // Abort drops any partial sum and pending result but keeps the last o_acc.
            state_reg  <= IDLE;
            acc_reg    <= '0;
            count_reg  <= '0;
            sticky_reg <= 1'b0;
            o_ready    <= 1'b1;
            o_valid    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, ACCUM: begin
                    o_ready <= 1'b1;
                    if (accept) begin
                        if (last_term) begin
                            o_acc      <= sum;
                            o_sat      <= sticky_reg | ovf;
                            o_valid    <= 1'b1;
                            o_ready    <= 1'b0;
                            acc_reg    <= '0;
                            count_reg  <= '0;
                            sticky_reg <= 1'b0;
                            state_reg  <= HOLD;
                        end else begin
                            acc_reg    <= sum;
                            sticky_reg <= sticky_reg | ovf;
                            count_reg  <= count_reg + 8'd1;
                            state_reg  <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (i_ready) begin
                        o_valid   <= 1'b0;
                        o_ready   <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    o_valid   <= 1'b0;
                    o_ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/alm_dot_accum.md
# alm_dot_accum

Streaming signed accumulator that sits directly downstream of the 8-bit signed approximate log multiplier. It consumes one 16-bit signed product per accepted beat and sums VEC_LEN products into a saturating accumulator. It presents the dot-product result on a valid/ready output port. Typical use is the reduction stage of an approximate-MAC datapath; its error statistics are compared against exact-multiplier dot products.

## Interface
- VEC_LEN, 8: products summed per result; legal range 2..256.
- ACC_WIDTH, 24: accumulator/result width in bits; legal range 16..32.
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset; asynchronous, active-high.
- i_valid  input  1  i_prod holds a valid product.
- o_ready  output  1  block can accept a product this cycle.
- i_prod  input  16  signed product from the multiplier (o_z).
- i_clear  input  1  synchronous abort; discards partial sum and any pending result.
- o_valid  output  1  o_acc holds a completed result.
- i_ready  input  1  downstream consumes the result.
- o_acc  output  ACC_WIDTH  signed dot-product result.
- o_sat  output  1  at least one saturation occurred while forming o_acc.
- o_count  output  8  number of products accepted in the current vector (0..VEC_LEN-1).

## Operation
- States:
  - IDLE: no partial sum.
  - ACCUM: 1..VEC_LEN-1 terms accepted.
  - HOLD: result pending.
- o_ready is 1 in IDLE/ACCUM and 0 in HOLD.
- A beat is accepted when i_valid && o_ready at a rising edge.
- On accept:
  - next = acc + sign_extend(i_prod).
  - Form the sum at ACC_WIDTH+1 bits and clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - On clamp, set the sticky saturation flag.
  - Increment the count.
- On the VEC_LEN-th accept:
  - Load the clamped sum into o_acc and the sticky flag into o_sat.
  - Assert o_valid and enter HOLD.
  - Zero the internal acc, count and sticky flag in the same edge.
- HOLD with i_ready=1 at an edge: o_valid drops, state goes to IDLE, o_ready returns to 1 on the next cycle.
- No input beat is accepted in the cycle of result handoff.
- o_acc and o_sat stay stable while o_valid=1 and are unchanged after handoff until the next result loads.
- i_clear=1 at an edge, from any state:
  - Clear acc, count, sticky flag and o_valid, and go to IDLE.
  - A concurrent input beat is discarded.
  - o_acc is not zeroed.
- Priority: i_rst > i_clear > handoff/accept.
- i_prod = 0 is a valid term and counts toward VEC_LEN.

## Timing
- Reset values:
  - state IDLE; o_valid 0; o_acc 0; o_sat 0; o_count 0.
  - o_ready 0 while i_rst is high. o_ready is registered and rises at the first rising edge after i_rst deasserts.
- Throughput: one product per cycle within a vector.
- Per vector: VEC_LEN accept cycles plus at least 1 handoff cycle.
- Latency: o_valid rises one cycle after the edge that accepts the last term.
- Reset asserted mid-vector or in HOLD: outputs return to reset values immediately (asynchronous); the partial sum is lost.
- i_valid may toggle freely; an idle cycle does not advance the count.
- o_count is registered and equals the accepted terms of the current vector.

## Structure
- Shared package alm_pkg holds:
  - state enum (IDLE, ACCUM, HOLD);
  - product width constant PROD_WIDTH=16;
  - saturation limit functions sat_max(w) and sat_min(w).
- Sub-module alm_sat_add: combinational signed add of ACC_WIDTH acc plus 16-bit product, producing the clamped sum and an overflow flag.
- Top holds the FSM, counter, output registers and handshake.

## Test plan
- **Basic vector (VEC_LEN=4, ACC_WIDTH=24):**
  - Stimulus: products 100, -50, 16384, -1 on consecutive cycles, i_ready=1.
  - Required: o_acc=16433, o_sat=0, o_valid for exactly 1 cycle, one cycle after the 4th accept.
- **Backpressure:**
  - Stimulus: same vector with i_ready=0 for 5 cycles.
  - Required: o_ready=0, o_acc stable, i_valid beats ignored; 1 cycle after i_ready=1, o_ready=1 and the next vector starts from 0.
- **Saturation (ACC_WIDTH=16, VEC_LEN=3):**
  - Stimulus: 16384, 16384, 16384.
  - Required: o_acc=32767, o_sat=1.
  - Stimulus: -16384 ×3.
  - Required: o_acc=-32768, o_sat=1; next clean vector reports o_sat=0.
- **Gapped input:**
  - Stimulus: i_valid pattern 1,0,0,1,1,0,1 with products 1,2,3,4.
  - Required: o_count steps 1,1,1,2,3,3 then result 10.
- **Clear mid-vector:**
  - Stimulus: two terms 7, 9, then i_clear with i_valid=1 and i_prod=5, then four terms of 1.
  - Required: o_acc=4; the 5 is not counted.
- **Async reset in HOLD:**
  - Stimulus: assert i_rst between edges.
  - Required: o_valid, o_acc and o_count go to 0 without a clock; o_ready rises at the first edge after release.
